fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Reads the current PC from the PC register and computes the value the PC register loads next.
- Issues word requests to instruction memory over a valid/ready handshake, tolerating variable response latency.
- Delivers the IF/ID pipeline register (valid, pc, pc+4, instr) to decode, with ID stall, redirect/flush and a one-entry skid buffer.

Parameters:
XLEN, 32, address/data width
NOP_INSTR, 32'h00000013, instruction placed in IF/ID on bubble or flush (addi x0,x0,0)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
pc_cur  input  XLEN  current PC from the PC register
pc_next  output  XLEN  next PC into the PC register (PC register loads every cycle)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (= pc_cur)
imem_rsp_valid  input  1  response valid (one cycle, in order, never before acceptance)
imem_rsp_data  input  32  fetched instruction
redirect_valid  input  1  branch/jump taken: flush and redirect
redirect_pc  input  XLEN  redirect target
stall_id  input  1  decode cannot accept; IF/ID holds
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  XLEN  PC of that instruction
if_id_pc_plus4  output  XLEN  if_id_pc + 4
if_id_instr  output  32  instruction (NOP_INSTR when invalid)

Behaviour:
- Reset is asynchronous, active-high, on clk:
  - state = ISSUE, skid empty.
  - if_id_valid = 0, if_id_pc = 0, if_id_pc_plus4 = 4, if_id_instr = NOP_INSTR.
- At most one request outstanding.
- FSM states:
  - ISSUE: imem_req_valid = !skid_valid, imem_req_addr = pc_cur.
    - On fire (valid & ready): go to WAIT, or to DISCARD if redirect_valid in the same cycle.
  - WAIT: imem_req_valid = 0.
    - On imem_rsp_valid: go to ISSUE; the response is accepted unless redirect_valid.
    - No response and redirect_valid: go to DISCARD.
  - DISCARD: on imem_rsp_valid, drop the data and go to ISSUE. Redirect here keeps state DISCARD.
- pc_next priority:
  1. redirect_valid: {redirect_pc[XLEN-1:2], 2'b00}
  2. request fire: pc_cur + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0)
  3. otherwise: pc_cur
- Tag register: captures pc_cur on fire and supplies the PC for the returning response.
- IF/ID update each cycle, in priority order:
  - redirect_valid: if_id_valid <= 0, instr <= NOP_INSTR, skid cleared. Redirect overrides stall_id.
  - if_id_valid & stall_id: IF/ID holds. An accepted response in this case goes to the skid.
  - skid_valid: IF/ID loads from the skid; the skid empties.
  - accepted response: IF/ID loads {1, tag, tag+4, data}.
  - otherwise: bubble (valid <= 0, instr <= NOP_INSTR; pc fields may hold).
- The skid cannot overflow, because no request issues while it is full.
- Throughput: 1-cycle memory gives one instruction per 2 cycles (ISSUE/WAIT alternate). Back-to-back issue is out of scope.
- Outputs are registered except imem_req_valid, imem_req_addr and pc_next.
- Reset mid-operation: the outstanding request is forgotten. The memory must also be reset; a late response after reset is undefined.

Decomposition:
- Shared package: XLEN, NOP_INSTR, fetch FSM state encoding (ISSUE, WAIT, DISCARD).
- One sub-module is natural: if_id_reg, holding the IF/ID register and the skid entry with their stall/flush/load logic.
- FSM and pc_next logic stay in fetch_unit.

Test Plan:
- Reset, ready=1, 1-cycle memory returning addr-based data:
  - first request addr 0x0; pc_next = 0x4 on fire.
  - IF/ID then shows pc 0x0, pc_plus4 0x4, valid=1.
  - the sequence continues at 0x4, 0x8.
- imem_req_ready low 3 cycles at pc 0x10 -> req_valid held, pc_next stays 0x10; fire on cycle 4, then pc_next = 0x14.
- Redirect to 0x103 while in WAIT for 0x20:
  - pc_next = 0x100, if_id_valid = 0, instr = 0x00000013.
  - the 0x20 response is dropped; the next request addr is 0x100.
- stall_id held with IF/ID valid at 0x8 when the 0xC response arrives:
  - IF/ID keeps 0x8; 0xC goes to the skid; no new request issues.
  - after stall release, IF/ID = 0xC.
- Redirect together with stall_id and a full skid -> both cleared, valid = 0, pc_next = redirect target.
- pc_cur 0xFFFFFFFC fires -> pc_next = 0x00000000; if_id_pc_plus4 = 0x00000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Returned instruction paired with the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register plus a one-entry skid that catches a response
// arriving while decode is stalled.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            rsp_valid_i,
  input  fetch_pkt_t      rsp_i,
  output logic            skid_valid_o,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_plus4_o,
  output logic [ILEN-1:0] if_id_instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            skid_valid_q, skid_valid_d;
  fetch_pkt_t      skid_q, skid_d;

  // Priority: flush, stalled hold, skid drain, fresh response, bubble
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (valid_q && stall_i) begin
      if (rsp_valid_i) begin
        skid_valid_d = 1'b1;
        skid_d       = rsp_i;
      end
    end else if (skid_valid_q) begin
      valid_d      = 1'b1;
      pc_d         = skid_q.pc;
      pc4_d        = skid_q.pc + XLEN'(4);
      instr_d      = skid_q.instr;
      skid_valid_d = 1'b0;
    end else if (rsp_valid_i) begin
      valid_d = 1'b1;
      pc_d    = rsp_i.pc;
      pc4_d   = rsp_i.pc + XLEN'(4);
      instr_d = rsp_i.instr;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      pc4_q        <= XLEN'(4);
      instr_q      <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign skid_valid_o     = skid_valid_q;
  assign if_id_valid_o    = valid_q;
  assign if_id_pc_o       = pc_q;
  assign if_id_pc_plus4_o = pc4_q;
  assign if_id_instr_o    = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, next-PC selection,
// and delivery into the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_id,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [ILEN-1:0] if_id_instr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] tag_q;
  logic            req_valid_c;
  logic            fire_c;
  logic            rsp_accept_c;
  logic            skid_valid;
  fetch_pkt_t      rsp_pkt;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Fetch FSM: issue, wait for the response, or swallow a stale one
  always_comb begin
    state_d      = state_q;
    req_valid_c  = 1'b0;
    rsp_accept_c = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        req_valid_c = !skid_valid;
        if (req_valid_c && imem_req_ready) begin
          state_d = redirect_valid ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d      = ST_ISSUE;
          rsp_accept_c = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_rsp_valid) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  assign fire_c         = req_valid_c && imem_req_ready;
  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = pc_cur;

  always_comb begin
    pc_next = pc_cur;
    if (redirect_valid) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fire_c) begin
      pc_next = pc_cur + XLEN'(4);
    end
  end

  // Tag remembers which PC the outstanding request belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ISSUE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fire_c) begin
        tag_q <= pc_cur;
      end
    end
  end

  assign rsp_pkt.pc    = tag_q;
  assign rsp_pkt.instr = imem_rsp_data;

  fetch_unit_if_id_reg u_if_id_reg (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (redirect_valid),
    .stall_i          (stall_id),
    .rsp_valid_i      (rsp_accept_c),
    .rsp_i            (rsp_pkt),
    .skid_valid_o     (skid_valid),
    .if_id_valid_o    (if_id_valid),
    .if_id_pc_o       (if_id_pc),
    .if_id_pc_plus4_o (if_id_pc_plus4),
    .if_id_instr_o    (if_id_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and variable-latency imem model, a
// per-cycle vector table and a scoreboard of expected IF/ID deliveries.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur, pc_next;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_id       (stall_id),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  // PC register loads pc_next every cycle
  always @(posedge clk or posedge reset) begin
    if (reset) pc_cur <= '0;
    else       pc_cur <= pc_next;
  end

  // Instruction memory: response mem_lat cycles after acceptance, data = ~addr
  int unsigned mem_lat;
  int unsigned mem_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else begin
      if (mem_busy) begin
        if (mem_cnt <= 1) mem_busy <= 1'b0;
        else              mem_cnt  <= mem_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat;
        mem_addr <= imem_req_addr;
      end
    end
  end
  assign imem_rsp_valid = mem_busy && (mem_cnt == 1);
  assign imem_rsp_data  = ~mem_addr;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rdy, st, rd;
    logic [31:0] rpc;
    logic        exp_rv;
    logic [31:0] exp_addr, exp_pcn;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NV = 31;
  vec_t vt [NV];

  exp_t        sbq [$];
  exp_t        cur;
  logic        m_valid;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        p_fire, p_redir, p_hold;
  logic [31:0] p_addr;

  function automatic vec_t mk(input logic rdy, st, rd, input logic [31:0] rpc,
                              input logic rv, input logic [31:0] a, pn,
                              input logic v, input logic [31:0] pc);
    vec_t t;
    t.rdy = rdy; t.st = st; t.rd = rd; t.rpc = rpc;
    t.exp_rv = rv; t.exp_addr = a; t.exp_pcn = pn; t.exp_v = v; t.exp_pc = pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and latch what fires
  task automatic drive(input logic rdy, st, rd, input logic [31:0] rpc);
    @(negedge clk);
    imem_req_ready = rdy;
    stall_id       = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    p_fire  = imem_req_valid && imem_req_ready;
    p_addr  = imem_req_addr;
    p_redir = rd;
    p_hold  = m_valid && st;
  endtask

  // Advance past the edge and check IF/ID against the scoreboard
  task automatic commit();
    exp_t e;
    @(posedge clk);
    #1;
    if (p_redir) begin
      sbq.delete();
      m_valid = 1'b0;
      chk("flush_valid", 32'(if_id_valid), 32'd0);
      chk("flush_instr", if_id_instr, NOP_INSTR);
    end else begin
      if (p_fire) sbq.push_back(exp_t'{pc: p_addr, pc4: p_addr + 32'd4, instr: ~p_addr});
      if (p_hold) begin
        chk("hold_valid", 32'(if_id_valid), 32'd1);
        chk("hold_pc", if_id_pc, cur.pc);
        chk("hold_instr", if_id_instr, cur.instr);
      end else if (if_id_valid) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_miss++;
          $display("FAIL sb_unexpected: got valid pc %08h expected no delivery", if_id_pc);
        end else begin
          n_vec--;
          e = sbq.pop_front();
          cur = e;
          m_valid = 1'b1;
          chk("sb_pc", if_id_pc, e.pc);
          chk("sb_pc_plus4", if_id_pc_plus4, e.pc4);
          chk("sb_instr", if_id_instr, e.instr);
        end
      end else begin
        m_valid = 1'b0;
        chk("bubble_instr", if_id_instr, NOP_INSTR);
      end
    end
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (sbq.size() != 0 && n < budget) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      commit();
      n++;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending after %0d cycles expected 0", sbq.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(1,0,0,0,           1, 32'h0,        32'h4,        0, 0);
    vt[1]  = mk(1,0,0,0,           0, 32'h4,        32'h4,        1, 32'h0);
    vt[2]  = mk(1,0,0,0,           1, 32'h4,        32'h8,        0, 0);
    vt[3]  = mk(1,0,0,0,           0, 32'h8,        32'h8,        1, 32'h4);
    vt[4]  = mk(1,0,0,0,           1, 32'h8,        32'hC,        0, 0);
    vt[5]  = mk(1,0,0,0,           0, 32'hC,        32'hC,        1, 32'h8);
    vt[6]  = mk(1,1,0,0,           1, 32'hC,        32'h10,       1, 32'h8);
    vt[7]  = mk(1,1,0,0,           0, 32'h10,       32'h10,       1, 32'h8);
    vt[8]  = mk(1,1,0,0,           0, 32'h10,       32'h10,       1, 32'h8);
    vt[9]  = mk(1,0,0,0,           0, 32'h10,       32'h10,       1, 32'hC);
    vt[10] = mk(0,0,0,0,           1, 32'h10,       32'h10,       0, 0);
    vt[11] = mk(0,0,0,0,           1, 32'h10,       32'h10,       0, 0);
    vt[12] = mk(0,0,0,0,           1, 32'h10,       32'h10,       0, 0);
    vt[13] = mk(1,0,0,0,           1, 32'h10,       32'h14,       0, 0);
    vt[14] = mk(1,0,0,0,           0, 32'h14,       32'h14,       1, 32'h10);
    vt[15] = mk(1,0,0,0,           1, 32'h14,       32'h18,       0, 0);
    vt[16] = mk(1,0,0,0,           0, 32'h18,       32'h18,       1, 32'h14);
    vt[17] = mk(1,0,0,0,           1, 32'h18,       32'h1C,       0, 0);
    vt[18] = mk(1,0,0,0,           0, 32'h1C,       32'h1C,       1, 32'h18);
    vt[19] = mk(1,0,0,0,           1, 32'h1C,       32'h20,       0, 0);
    vt[20] = mk(1,0,0,0,           0, 32'h20,       32'h20,       1, 32'h1C);
    vt[21] = mk(1,0,0,0,           1, 32'h20,       32'h24,       0, 0);
    vt[22] = mk(1,0,1,32'h103,     0, 32'h24,       32'h100,      0, 0);
    vt[23] = mk(1,0,0,0,           1, 32'h100,      32'h104,      0, 0);
    vt[24] = mk(1,0,0,0,           0, 32'h104,      32'h104,      1, 32'h100);
    vt[25] = mk(1,0,1,32'hFFFFFFFC,1, 32'h104,      32'hFFFFFFFC, 0, 0);
    vt[26] = mk(1,0,0,0,           0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0);
    vt[27] = mk(1,0,0,0,           1, 32'hFFFFFFFC, 32'h0,        0, 0);
    vt[28] = mk(1,0,0,0,           0, 32'h0,        32'h0,        1, 32'hFFFFFFFC);
    vt[29] = mk(1,0,0,0,           1, 32'h0,        32'h4,        0, 0);
    vt[30] = mk(1,0,0,0,           0, 32'h4,        32'h4,        1, 32'h0);

    mem_lat        = 1;
    m_valid        = 1'b0;
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc_plus4", if_id_pc_plus4, 32'h4);
    chk("rst_instr", if_id_instr, NOP_INSTR);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rdy, vt[i].st, vt[i].rd, vt[i].rpc);
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].exp_rv));
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].exp_addr);
      chk($sformatf("v%0d_pc_next", i), pc_next, vt[i].exp_pcn);
      commit();
      chk($sformatf("v%0d_if_valid", i), 32'(if_id_valid), 32'(vt[i].exp_v));
      if (vt[i].exp_v) chk($sformatf("v%0d_if_pc", i), if_id_pc, vt[i].exp_pc);
    end

    // Slow memory: redirects during WAIT and DISCARD, stale response dropped
    mem_lat = 3;
    drive(1, 0, 0, 32'h0);
    chk("a0_pc_next", pc_next, 32'h8);
    commit();
    drive(1, 0, 1, 32'h200);
    chk("a1_pc_next", pc_next, 32'h200);
    chk("a1_req_valid", 32'(imem_req_valid), 32'd0);
    commit();
    drive(1, 0, 1, 32'h301);
    chk("a2_pc_next", pc_next, 32'h300);
    commit();
    drive(1, 0, 0, 32'h0);
    chk("a3_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    chk("a3_req_valid", 32'(imem_req_valid), 32'd0);
    commit();
    drive(1, 0, 0, 32'h0);
    chk("a4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("a4_req_addr", imem_req_addr, 32'h300);
    chk("a4_pc_next", pc_next, 32'h304);
    commit();
    drain(20);

    // Redirect with stall and a full skid clears both
    mem_lat = 1;
    drive(1, 0, 0, 32'h0);
    chk("b0_req_addr", imem_req_addr, 32'h304);
    commit();
    drive(1, 0, 0, 32'h0); commit();
    drive(1, 1, 0, 32'h0); commit();
    drive(1, 1, 0, 32'h0); commit();
    drive(1, 1, 1, 32'h400);
    chk("b4_req_valid", 32'(imem_req_valid), 32'd0);
    chk("b4_pc_next", pc_next, 32'h400);
    commit();
    drive(1, 0, 0, 32'h0);
    chk("b5_req_valid", 32'(imem_req_valid), 32'd1);
    chk("b5_req_addr", imem_req_addr, 32'h400);
    commit();
    chk("b5_if_valid", 32'(if_id_valid), 32'd0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
